// File: rtl/cam_read_if.sv
// Camera-to-frame-buffer bundle for cam_read.
// Groups the OV7670 parallel bus inputs with the dual-port RAM write port.
// The master side is the camera/bus driver and the slave side is the capture block.
// When CAM_READ_STATS_EN is defined, the frame counter and line error flag are also carried here.
interface cam_read_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_regW;
  logic          frame_done;
`ifdef CAM_READ_STATS_EN
  logic [7:0]    frame_cnt;
  logic          line_err;
`endif

  modport master (
    output CAM_vsync,
    output CAM_href,
    output CAM_px_data,
    input  DP_RAM_addr_in,
    input  DP_RAM_data_in,
    input  DP_RAM_regW,
`ifdef CAM_READ_STATS_EN
    input  frame_cnt,
    input  line_err,
`endif
    input  frame_done
  );

  modport slave (
    input  CAM_vsync,
    input  CAM_href,
    input  CAM_px_data,
    output DP_RAM_addr_in,
    output DP_RAM_data_in,
    output DP_RAM_regW,
`ifdef CAM_READ_STATS_EN
    output frame_cnt,
    output line_err,
`endif
    output frame_done
  );
endinterface

// File: rtl/cam_read.sv
// cam_read: OV7670 capture block.
// Packs each pair of RGB444 bytes into one 12-bit pixel and writes it into a
// linear IMG_W x IMG_H frame buffer. A frame is armed by a vsync high->low
// sequence. Writes beyond the last pixel are suppressed until the next vsync.
// Optional statistics (frame counter, sticky line error) are built only when
// the macro CAM_READ_STATS_EN is defined.
module cam_read #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic       clk,
  input  logic       rst,
  cam_read_if.slave  cam
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_FRAME,
    IDLE,
    BYTE1,
    BYTE0
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    byte0_q, byte0_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          regw_q, regw_d;
  logic          frame_done_q, frame_done_d;
  logic          full_q, full_d;

  // Next-state, pixel packing and address bookkeeping for the capture FSM
  always_comb begin
    state_d      = state_q;
    byte0_d      = byte0_q;
    addr_d       = addr_q;
    data_d       = data_q;
    regw_d       = 1'b0;
    frame_done_d = 1'b0;
    full_d       = full_q;

    // The address advances the cycle after a strobe; the last pixel instead
    // freezes the address, blocks further writes and pulses frame_done.
    if (regw_q) begin
      if (addr_q == LAST_ADDR) begin
        full_d       = 1'b1;
        frame_done_d = 1'b1;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end

    case (state_q)
      WAIT_VS: begin
        if (cam.CAM_vsync) begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // Falling vsync arms a fresh frame at pixel 0
        if (!cam.CAM_vsync) begin
          state_d = IDLE;
          addr_d  = '0;
          full_d  = 1'b0;
        end
      end
      IDLE: begin
        if (cam.CAM_vsync) begin
          state_d = WAIT_FRAME;
        end else if (cam.CAM_href) begin
          byte0_d = cam.CAM_px_data[3:0];
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        // vsync takes priority over a byte1 sampled in the same cycle
        if (cam.CAM_vsync) begin
          state_d = WAIT_FRAME;
        end else if (cam.CAM_href) begin
          if (!full_q) begin
            data_d = DW'({byte0_q, cam.CAM_px_data});
            regw_d = 1'b1;
          end
          state_d = BYTE0;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE0: begin
        if (cam.CAM_vsync) begin
          state_d = WAIT_FRAME;
        end else if (cam.CAM_href) begin
          byte0_d = cam.CAM_px_data[3:0];
          state_d = BYTE1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_VS;
      end
    endcase
  end

  // Capture state and registered RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_VS;
      byte0_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      regw_q       <= 1'b0;
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte0_q      <= byte0_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      regw_q       <= regw_d;
      frame_done_q <= frame_done_d;
      full_q       <= full_d;
    end
  end

  assign cam.DP_RAM_addr_in = addr_q;
  assign cam.DP_RAM_data_in = data_q;
  assign cam.DP_RAM_regW    = regw_q;
  assign cam.frame_done     = frame_done_q;

`ifdef CAM_READ_STATS_EN
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        line_err_q, line_err_d;
  logic        href_q, href_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        capturing;

  assign capturing = (state_q == IDLE) || (state_q == BYTE1) || (state_q == BYTE0);

  // Frame counting and line/frame geometry checking
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    line_err_d  = line_err_q;
    href_d      = cam.CAM_href;
    byte_cnt_d  = byte_cnt_q;
    line_cnt_d  = line_cnt_q;

    // Counter moves in the same edge that raises frame_done
    if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if ((state_q == WAIT_FRAME) && !cam.CAM_vsync) begin
      byte_cnt_d = '0;
      line_cnt_d = '0;
    end else if (capturing) begin
      if (cam.CAM_vsync) begin
        // Frame ends: a truncated line or wrong line count is an error
        if (href_q || (line_cnt_q != 16'(IMG_H))) begin
          line_err_d = 1'b1;
        end
        byte_cnt_d = '0;
      end else if (cam.CAM_href) begin
        if (byte_cnt_q != 16'hFFFF) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
        end
      end else if (href_q) begin
        // Falling href closes a line
        if (byte_cnt_q != 16'(2 * IMG_W)) begin
          line_err_d = 1'b1;
        end
        if (line_cnt_q != 16'hFFFF) begin
          line_cnt_d = line_cnt_q + 16'd1;
        end
        byte_cnt_d = '0;
      end
    end
  end

  // Statistics registers; line_err is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      line_err_q  <= 1'b0;
      href_q      <= 1'b0;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      href_q      <= href_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign cam.frame_cnt = frame_cnt_q;
  assign cam.line_err  = line_err_q;
`endif

endmodule

// File: tb/tb_cam_read.sv
// Testbench for cam_read: a cycle-exact vector table for the short corner
// cases, then frame-level stimulus checked against a pixel-stream model.
module tb_cam_read;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NV    = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cam_read_if #(.AW(AW), .DW(DW)) cam ();

  cam_read #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  typedef struct {
    logic        rst;
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        w;
    logic [14:0] a;
    logic [11:0] dat;
    logic        fd;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  vec_t       tbl [NV];
  wr_t        exp_q[$];
  wr_t        mon_w;
  logic [7:0] line_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         pix = 0;
  bit         armed = 1'b0;
  int         exp_fd = 0;
  int         obs_fd = 0;
  bit         mon_en = 1'b0;
  bit         prev_w = 1'b0;

  function automatic vec_t mk(logic r, logic vs, logic hr, logic [7:0] d,
                              logic w, logic [14:0] a, logic [11:0] dat, logic fd);
    vec_t v;
    v.rst = r; v.vs = vs; v.hr = hr; v.d = d;
    v.w = w; v.a = a; v.dat = dat; v.fd = fd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: the frame is a stream of byte pairs, pixel index counts up from 0
  function automatic void model_frame_start();
    armed = 1'b1;
    pix   = 0;
  endfunction

  function automatic void model_pair(logic [7:0] b0, logic [7:0] b1);
    wr_t w;
    if (armed && pix < NPIX) begin
      w.a = AW'(pix);
      w.d = {b0[3:0], b1[7:4], b1[3:0]};
      exp_q.push_back(w);
      if (pix == NPIX - 1) exp_fd++;
      pix++;
    end
  endfunction

  function automatic void model_line(int n);
    for (int i = 0; i + 1 < n; i += 2) model_pair(line_q[i], line_q[i + 1]);
  endfunction

  // Write-port monitor compares every strobe against the model queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (cam.DP_RAM_regW === 1'b1) begin
        n_vec++;
        if (prev_w) begin
          n_err++;
          $display("[TB] FAIL strobe_width: regW high two cycles running at addr %0d", cam.DP_RAM_addr_in);
        end
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%03h, want no write",
                   cam.DP_RAM_addr_in, cam.DP_RAM_data_in);
        end else begin
          mon_w = exp_q.pop_front();
          if (cam.DP_RAM_addr_in !== mon_w.a || cam.DP_RAM_data_in !== mon_w.d) begin
            n_err++;
            $display("[TB] FAIL write: got addr %0d data 0x%03h, want addr %0d data 0x%03h",
                     cam.DP_RAM_addr_in, cam.DP_RAM_data_in, mon_w.a, mon_w.d);
          end
        end
      end
      if (cam.frame_done === 1'b1) obs_fd++;
    end
    prev_w = (cam.DP_RAM_regW === 1'b1);
  end

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam.CAM_vsync   = vs;
    cam.CAM_href    = hr;
    cam.CAM_px_data = d;
  endtask

  task automatic frame_start(input int hi);
    repeat (hi) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    model_frame_start();
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill_line(input int n, input bit konst, input logic [7:0] k);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(konst ? k : 8'($urandom));
  endtask

  // cut >= 0 raises vsync at byte index cut (with or without href) and leaves it high
  task automatic send_line(input int cut, input bit cut_href, input int gap);
    model_line((cut < 0) ? line_q.size() : cut);
    for (int j = 0; j < line_q.size(); j++) begin
      if (j == cut) begin
        applyStimulus(1'b1, cut_href, line_q[j]);
        return;
      end
      applyStimulus(1'b0, 1'b1, line_q[j]);
    end
    repeat (gap) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    checkOutput({name, "_pending_writes"}, exp_q.size(), 0);
    checkOutput({name, "_frame_done_count"}, obs_fd, exp_fd);
  endtask

  initial begin
    int fd_before;
    int nl;
    int len;
    int cut;

    cam.CAM_vsync   = 1'b0;
    cam.CAM_href    = 1'b0;
    cam.CAM_px_data = 8'h00;

    //                rst vs hr  data   w  addr   data    fd
    tbl[0]  = mk(1, 0, 0, 8'h00, 0, 15'd0, 12'h000, 0);
    tbl[1]  = mk(0, 0, 1, 8'hAA, 0, 15'd0, 12'h000, 0);
    tbl[2]  = mk(0, 1, 0, 8'h00, 0, 15'd0, 12'h000, 0);
    tbl[3]  = mk(0, 1, 0, 8'h00, 0, 15'd0, 12'h000, 0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 0, 15'd0, 12'h000, 0);
    tbl[5]  = mk(0, 0, 1, 8'h5A, 0, 15'd0, 12'h000, 0);
    tbl[6]  = mk(0, 0, 1, 8'hC3, 1, 15'd0, 12'hAC3, 0);
    tbl[7]  = mk(0, 0, 1, 8'h0F, 0, 15'd1, 12'hAC3, 0);
    tbl[8]  = mk(0, 0, 1, 8'hF0, 1, 15'd1, 12'hFF0, 0);
    tbl[9]  = mk(0, 0, 1, 8'h12, 0, 15'd2, 12'hFF0, 0);
    tbl[10] = mk(0, 0, 0, 8'h00, 0, 15'd2, 12'hFF0, 0);
    tbl[11] = mk(0, 0, 1, 8'h34, 0, 15'd2, 12'hFF0, 0);
    tbl[12] = mk(0, 0, 1, 8'h56, 1, 15'd2, 12'h456, 0);
    tbl[13] = mk(0, 0, 0, 8'h00, 0, 15'd3, 12'h456, 0);
    tbl[14] = mk(0, 0, 1, 8'h77, 0, 15'd3, 12'h456, 0);
    tbl[15] = mk(0, 1, 1, 8'h88, 0, 15'd3, 12'h456, 0);
    tbl[16] = mk(0, 1, 0, 8'h00, 0, 15'd3, 12'h456, 0);
    tbl[17] = mk(0, 0, 0, 8'h00, 0, 15'd0, 12'h456, 0);
    tbl[18] = mk(0, 0, 1, 8'h09, 0, 15'd0, 12'h456, 0);
    tbl[19] = mk(0, 0, 1, 8'hAB, 1, 15'd0, 12'h9AB, 0);
    tbl[20] = mk(0, 0, 0, 8'h00, 0, 15'd1, 12'h9AB, 0);
    tbl[21] = mk(1, 0, 0, 8'h00, 0, 15'd0, 12'h000, 0);
    tbl[22] = mk(0, 0, 1, 8'h11, 0, 15'd0, 12'h000, 0);
    tbl[23] = mk(0, 0, 1, 8'h22, 0, 15'd0, 12'h000, 0);
    tbl[24] = mk(0, 0, 0, 8'h00, 0, 15'd0, 12'h000, 0);

    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("vec%0d_regW", i - 1), 32'(cam.DP_RAM_regW), 32'(tbl[i - 1].w));
        checkOutput($sformatf("vec%0d_addr", i - 1), 32'(cam.DP_RAM_addr_in), 32'(tbl[i - 1].a));
        checkOutput($sformatf("vec%0d_data", i - 1), 32'(cam.DP_RAM_data_in), 32'(tbl[i - 1].dat));
        checkOutput($sformatf("vec%0d_frame_done", i - 1), 32'(cam.frame_done), 32'(tbl[i - 1].fd));
      end
      if (i < NV) begin
        rst             = tbl[i].rst;
        cam.CAM_vsync   = tbl[i].vs;
        cam.CAM_href    = tbl[i].hr;
        cam.CAM_px_data = tbl[i].d;
      end
    end

    mon_en = 1'b1;

    $display("[TB] odd-length line");
    frame_start(4);
    fill_line(2 * IMG_W, 1'b0, 8'h00);
    send_line(-1, 1'b0, 2);
`ifdef CAM_READ_STATS_EN
    checkOutput("line_err_clean_line", 32'(cam.line_err), 32'd0);
`endif
    fill_line(2 * IMG_W + 1, 1'b0, 8'h00);
    send_line(-1, 1'b0, 2);
`ifdef CAM_READ_STATS_EN
    checkOutput("line_err_odd_line", 32'(cam.line_err), 32'd1);
`endif
    fill_line(2 * IMG_W, 1'b0, 8'h00);
    send_line(-1, 1'b0, 2);
    drain("odd_line");

    $display("[TB] mid-line abort");
    frame_start(4);
    fill_line(250, 1'b0, 8'h00);
    send_line(100, 1'b0, 2);
    frame_start(4);
    fill_line(40, 1'b0, 8'h00);
    send_line(-1, 1'b0, 2);
    drain("abort");

    $display("[TB] full frame with one extra line");
    fd_before = obs_fd;
    frame_start(2 * (2 * IMG_W + 2));
    for (int l = 0; l < IMG_H + 1; l++) begin
      fill_line(2 * IMG_W, 1'b1, 8'h0F);
      send_line(-1, 1'b0, 2);
    end
    drain("full_frame");
    checkOutput("frame_done_once", obs_fd - fd_before, 1);
    checkOutput("addr_holds_last", 32'(cam.DP_RAM_addr_in), NPIX - 1);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      frame_start($urandom_range(1, 6));
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(1, 30);
        fill_line(len, 1'b0, 8'h00);
        cut = (l == nl - 1 && ($urandom % 2) == 1) ? $urandom_range(0, len - 1) : -1;
        send_line(cut, 1'($urandom % 2), $urandom_range(1, 3));
      end
    end
    frame_start(3);
    drain("random");

    $display("[TB] mid-frame reset");
    frame_start(4);
    for (int l = 0; l < 49; l++) begin
      fill_line(2 * IMG_W, 1'b0, 8'h00);
      send_line(-1, 1'b0, 2);
    end
    fill_line(2 * IMG_W, 1'b0, 8'h00);
    model_line(100);
    armed = 1'b0;
    for (int j = 0; j < 2 * IMG_W; j++) begin
      @(negedge clk);
      if (j == 101) begin
        rst = 1'b0;
        checkOutput("reset_regW", 32'(cam.DP_RAM_regW), 32'd0);
        checkOutput("reset_addr", 32'(cam.DP_RAM_addr_in), 32'd0);
        checkOutput("reset_data", 32'(cam.DP_RAM_data_in), 32'd0);
        checkOutput("reset_frame_done", 32'(cam.frame_done), 32'd0);
      end
      if (j == 100) rst = 1'b1;
      cam.CAM_href    = 1'b1;
      cam.CAM_px_data = line_q[j];
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 2; l++) begin
      fill_line(2 * IMG_W, 1'b0, 8'h00);
      send_line(-1, 1'b0, 2);
    end
    checkOutput("post_reset_addr", 32'(cam.DP_RAM_addr_in), 32'd0);
    frame_start(4);
    fill_line(20, 1'b0, 8'h00);
    send_line(-1, 1'b0, 2);
    drain("reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
